// File: rtl/nx_node_inbound_pkg.sv
// rtl/nx_node_inbound_pkg.sv - shared constants, message structs and row-then-column routing
package nx_node_inbound_pkg;

  localparam int STREAM_WIDTH   = 32;
  localparam int ADDR_ROW_WIDTH = 4;
  localparam int ADDR_COL_WIDTH = 4;
  localparam int COMMAND_WIDTH  = 2;
  localparam int INPUTS         = 8;
  localparam int OUTPUTS        = 8;
  localparam int MAX_IO         = (INPUTS > OUTPUTS) ? INPUTS : OUTPUTS;
  localparam int IO_W           = $clog2(MAX_IO);
  localparam int IDX_W          = $clog2(OUTPUTS);
  localparam int PAYLOAD_WIDTH  = STREAM_WIDTH - 1 - ADDR_ROW_WIDTH - ADDR_COL_WIDTH - COMMAND_WIDTH;
  localparam int BC_DECAY_WIDTH = ADDR_ROW_WIDTH + ADDR_COL_WIDTH;
  localparam int SIG_W          = ADDR_ROW_WIDTH + ADDR_COL_WIDTH + IDX_W + 1;
  localparam int CFG_W          = IO_W + ADDR_ROW_WIDTH + ADDR_COL_WIDTH + IDX_W + 4;

  localparam logic [BC_DECAY_WIDTH-1:0] DECAY_ONE = 1;

  localparam logic [COMMAND_WIDTH-1:0] CMD_LOAD_INSTR = 2'd0;
  localparam logic [COMMAND_WIDTH-1:0] CMD_CONFIGURE  = 2'd1;
  localparam logic [COMMAND_WIDTH-1:0] CMD_SIG_STATE  = 2'd2;
  localparam logic [COMMAND_WIDTH-1:0] CMD_RESERVED   = 2'd3;

  localparam logic [1:0] DIR_NORTH = 2'd0;
  localparam logic [1:0] DIR_EAST  = 2'd1;
  localparam logic [1:0] DIR_SOUTH = 2'd2;
  localparam logic [1:0] DIR_WEST  = 2'd3;

  typedef struct packed {
    logic                      bc;
    logic [ADDR_ROW_WIDTH-1:0] row;
    logic [ADDR_COL_WIDTH-1:0] col;
    logic [COMMAND_WIDTH-1:0]  cmd;
    logic [PAYLOAD_WIDTH-1:0]  payload;
  } msg_t;

  // Payload structs cover only the meaningful top bits; the zero pad is sliced off.
  typedef struct packed {
    logic [ADDR_ROW_WIDTH-1:0] src_row;
    logic [ADDR_COL_WIDTH-1:0] src_col;
    logic [IDX_W-1:0]          src_idx;
    logic                      state;
  } sig_payload_t;

  typedef struct packed {
    logic [IO_W-1:0]           io;
    logic                      is_input;
    logic [ADDR_ROW_WIDTH-1:0] rrow;
    logic [ADDR_COL_WIDTH-1:0] rcol;
    logic [IDX_W-1:0]          ridx;
    logic                      slot;
    logic                      bc;
    logic                      seq;
  } cfg_payload_t;

  function automatic logic [3:0] dir_bit(input logic [1:0] d);
    return 4'b0001 << d;
  endfunction

  function automatic logic [1:0] route_dir(input logic [ADDR_ROW_WIDTH-1:0] row,
                                           input logic [ADDR_COL_WIDTH-1:0] col,
                                           input logic [ADDR_ROW_WIDTH-1:0] node_row,
                                           input logic [ADDR_COL_WIDTH-1:0] node_col);
    if (row < node_row) return DIR_NORTH;
    if (row > node_row) return DIR_SOUTH;
    if (col < node_col) return DIR_WEST;
    return DIR_EAST;
  endfunction

endpackage

// File: rtl/nx_node_inbound_if.sv
// rtl/nx_node_inbound_if.sv - directed message stream (data, side, valid/ready)
interface nx_node_inbound_if;
  import nx_node_inbound_pkg::*;

  logic [STREAM_WIDTH-1:0] tdata;
  logic [1:0]              tdir;
  logic                    tvalid;
  logic                    tready;

  modport master (output tdata, output tdir, output tvalid, input tready);
  modport slave  (input tdata, input tdir, input tvalid, output tready);
endinterface

// File: rtl/nx_node_inbound.sv
// rtl/nx_node_inbound.sv - inbound decode to local strobes plus bypass/broadcast re-forwarding
module nx_node_inbound
  import nx_node_inbound_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [ADDR_ROW_WIDTH-1:0] node_row_i,
  input  logic [ADDR_COL_WIDTH-1:0] node_col_i,
  output logic                      idle_o,
  nx_node_inbound_if.slave          msg,
  nx_node_inbound_if.master         byp,
  output logic [IO_W-1:0]           map_io_o,
  output logic                      map_input_o,
  output logic [ADDR_ROW_WIDTH-1:0] map_remote_row_o,
  output logic [ADDR_COL_WIDTH-1:0] map_remote_col_o,
  output logic [IDX_W-1:0]          map_remote_idx_o,
  output logic                      map_slot_o,
  output logic                      map_broadcast_o,
  output logic                      map_seq_o,
  output logic                      map_valid_o,
  output logic [ADDR_ROW_WIDTH-1:0] signal_remote_row_o,
  output logic [ADDR_COL_WIDTH-1:0] signal_remote_col_o,
  output logic [IDX_W-1:0]          signal_remote_idx_o,
  output logic                      signal_state_o,
  output logic                      signal_valid_o,
  output logic [PAYLOAD_WIDTH-1:0]  instr_data_o,
  output logic                      instr_valid_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FWD  = 1'b1;

  logic [0:0]               state_q, state_d;
  logic [3:0]               mask_q, mask_d;
  msg_t                     fwd_q, fwd_d;
  logic [PAYLOAD_WIDTH-1:0] pl_q, pl_d;
  logic                     map_v_q, map_v_d, sig_v_q, sig_v_d, instr_v_q, instr_v_d;

  msg_t                      in_msg;
  msg_t                      fwd_msg;
  logic [3:0]                fwd_mask;
  logic                      local_hit;
  logic [BC_DECAY_WIDTH-1:0] decay;
  logic [1:0]                cur_dir;
  sig_payload_t              sig;
  cfg_payload_t              cfg;

  assign in_msg    = msg.tdata;
  assign local_hit = in_msg.bc || (in_msg.row == node_row_i && in_msg.col == node_col_i);
  assign decay     = {in_msg.row, in_msg.col};

  // Broadcasts fan out from N/S arrivals to the far side plus E and W; E/W arrivals continue straight.
  always_comb begin
    fwd_msg  = in_msg;
    fwd_mask = 4'b0000;
    if (in_msg.bc) begin
      if (decay != '0) begin
        {fwd_msg.row, fwd_msg.col} = decay - DECAY_ONE;
        if (msg.tdir == DIR_NORTH || msg.tdir == DIR_SOUTH)
          fwd_mask = dir_bit(msg.tdir ^ 2'd2) | dir_bit(DIR_EAST) | dir_bit(DIR_WEST);
        else
          fwd_mask = dir_bit(msg.tdir ^ 2'd2);
      end
    end else if (!local_hit) begin
      fwd_mask = dir_bit(route_dir(in_msg.row, in_msg.col, node_row_i, node_col_i));
    end
  end

  always_comb begin
    cur_dir = DIR_NORTH;
    for (int i = 3; i >= 0; i--)
      if (mask_q[i]) cur_dir = 2'(i);
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    fwd_d     = fwd_q;
    pl_d      = pl_q;
    map_v_d   = 1'b0;
    sig_v_d   = 1'b0;
    instr_v_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (msg.tvalid) begin
        if (local_hit) begin
          pl_d      = in_msg.payload;
          map_v_d   = (in_msg.cmd == CMD_CONFIGURE);
          sig_v_d   = (in_msg.cmd == CMD_SIG_STATE);
          instr_v_d = (in_msg.cmd == CMD_LOAD_INSTR);
        end
        if (fwd_mask != 4'b0000) begin
          state_d = ST_FWD;
          mask_d  = fwd_mask;
          fwd_d   = fwd_msg;
        end
      end
    end else if (byp.tready) begin
      mask_d = mask_q & ~dir_bit(cur_dir);
      if (mask_d == 4'b0000) state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      mask_q    <= '0;
      fwd_q     <= '0;
      pl_q      <= '0;
      map_v_q   <= 1'b0;
      sig_v_q   <= 1'b0;
      instr_v_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      fwd_q     <= fwd_d;
      pl_q      <= pl_d;
      map_v_q   <= map_v_d;
      sig_v_q   <= sig_v_d;
      instr_v_q <= instr_v_d;
    end
  end

  assign msg.tready = (state_q == ST_IDLE);
  assign byp.tvalid = (state_q == ST_FWD);
  assign byp.tdata  = fwd_q;
  assign byp.tdir   = cur_dir;
  assign idle_o     = (state_q == ST_IDLE) && !(map_v_q || sig_v_q || instr_v_q);

  assign sig = pl_q[PAYLOAD_WIDTH-1 -: SIG_W];
  assign cfg = pl_q[PAYLOAD_WIDTH-1 -: CFG_W];

  assign signal_remote_row_o = sig.src_row;
  assign signal_remote_col_o = sig.src_col;
  assign signal_remote_idx_o = sig.src_idx;
  assign signal_state_o      = sig.state;
  assign signal_valid_o      = sig_v_q;

  assign map_io_o         = cfg.io;
  assign map_input_o      = cfg.is_input;
  assign map_remote_row_o = cfg.rrow;
  assign map_remote_col_o = cfg.rcol;
  assign map_remote_idx_o = cfg.ridx;
  assign map_slot_o       = cfg.slot;
  assign map_broadcast_o  = cfg.bc;
  assign map_seq_o        = cfg.seq;
  assign map_valid_o      = map_v_q;

  assign instr_data_o  = pl_q;
  assign instr_valid_o = instr_v_q;

endmodule

// File: tb/tb_nx_node_inbound.sv
// tb/tb_nx_node_inbound.sv - directed scoreboard bench for nx_node_inbound
module tb_nx_node_inbound;
  import nx_node_inbound_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] node_row = 4'd2;
  logic [3:0] node_col = 4'd3;
  logic       idle;

  logic [2:0]  map_io, map_ridx, sig_idx;
  logic [3:0]  map_rrow, map_rcol, sig_row, sig_col;
  logic        map_input, map_slot, map_bc, map_seq, map_valid;
  logic        sig_state, sig_valid, instr_valid;
  logic [20:0] instr_data;

  nx_node_inbound_if msg_if();
  nx_node_inbound_if byp_if();

  always #5 clk = ~clk;

  nx_node_inbound dut (
    .clk_i(clk), .rst_i(rst_n), .node_row_i(node_row), .node_col_i(node_col), .idle_o(idle),
    .msg(msg_if), .byp(byp_if),
    .map_io_o(map_io), .map_input_o(map_input), .map_remote_row_o(map_rrow),
    .map_remote_col_o(map_rcol), .map_remote_idx_o(map_ridx), .map_slot_o(map_slot),
    .map_broadcast_o(map_bc), .map_seq_o(map_seq), .map_valid_o(map_valid),
    .signal_remote_row_o(sig_row), .signal_remote_col_o(sig_col),
    .signal_remote_idx_o(sig_idx), .signal_state_o(sig_state), .signal_valid_o(sig_valid),
    .instr_data_o(instr_data), .instr_valid_o(instr_valid)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [11:0] sig_q[$];
  logic [17:0] map_q[$];
  logic [20:0] instr_q[$];
  logic [33:0] byp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic bc, input logic [3:0] r, input logic [3:0] c,
                                     input logic [1:0] cmd, input logic [20:0] pl);
    return {bc, r, c, cmd, pl};
  endfunction

  function automatic logic [20:0] sig_pl(input logic [3:0] r, input logic [3:0] c,
                                         input logic [2:0] idx, input logic st);
    return {r, c, idx, st, 9'b0};
  endfunction

  function automatic logic [20:0] cfg_pl(input logic [17:0] fields);
    return {fields, 3'b0};
  endfunction

  // Scoreboard: every strobe or bypass handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (sig_valid) begin
      if (sig_q.size() == 0) check("sig_unexpected", sig_valid, 1'b0);
      else check("sig_fields", {sig_row, sig_col, sig_idx, sig_state}, sig_q.pop_front());
    end
    if (map_valid) begin
      if (map_q.size() == 0) check("map_unexpected", map_valid, 1'b0);
      else check("map_fields", {map_io, map_input, map_rrow, map_rcol, map_ridx, map_slot, map_bc, map_seq},
                 map_q.pop_front());
    end
    if (instr_valid) begin
      if (instr_q.size() == 0) check("instr_unexpected", instr_valid, 1'b0);
      else check("instr_data", instr_data, instr_q.pop_front());
    end
    if (byp_if.tvalid && byp_if.tready) begin
      if (byp_q.size() == 0) check("byp_unexpected", byp_if.tvalid, 1'b0);
      else check("byp_dir_data", {byp_if.tdir, byp_if.tdata}, byp_q.pop_front());
    end
  end

  task automatic send(input logic [31:0] d, input logic [1:0] dir);
    int n = 0;
    @(posedge clk); #1;
    msg_if.tdata = d; msg_if.tdir = dir; msg_if.tvalid = 1'b1;
    @(negedge clk);
    while (!msg_if.tready && n < 50) begin n++; @(negedge clk); end
    check("send_ready", msg_if.tready, 1'b1);
    @(posedge clk); #1;
    msg_if.tvalid = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (!msg_if.tready && n < 20) begin n++; @(negedge clk); end
  endtask

  logic [31:0] m, f;
  int busy;

  initial begin
    msg_if.tdata = '0; msg_if.tdir = 2'd0; msg_if.tvalid = 1'b0;
    byp_if.tready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", msg_if.tready, 1'b1);
    check("rst_idle", idle, 1'b1);
    check("rst_byp_valid", byp_if.tvalid, 1'b0);
    check("rst_strobes", {sig_valid, map_valid, instr_valid}, 3'b000);
    @(posedge clk); #1 rst_n = 1'b1;

    // Unicast SIG_STATE to self
    sig_q.push_back({4'd1, 4'd1, 3'd5, 1'b1});
    send(mk(1'b0, 4'd2, 4'd3, CMD_SIG_STATE, sig_pl(4'd1, 4'd1, 3'd5, 1'b1)), DIR_WEST);
    @(negedge clk);
    check("t1_sig_n1", sig_valid, 1'b1);
    check("t1_byp_valid", byp_if.tvalid, 1'b0);
    check("t1_ready", msg_if.tready, 1'b1);
    @(negedge clk);
    check("t1_sig_once", sig_valid, 1'b0);

    // Unicast north with bypass backpressure
    m = mk(1'b0, 4'd0, 4'd3, CMD_SIG_STATE, sig_pl(4'd9, 4'd8, 3'd7, 1'b0));
    byp_if.tready = 1'b0;
    byp_q.push_back({DIR_NORTH, m});
    send(m, DIR_SOUTH);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_stall_valid", byp_if.tvalid, 1'b1);
      check("t2_stall_dir_data", {byp_if.tdir, byp_if.tdata}, {DIR_NORTH, m});
      check("t2_stall_ready", msg_if.tready, 1'b0);
    end
    @(posedge clk); #1 byp_if.tready = 1'b1;
    @(negedge clk);
    check("t2_hs_dir_data", {byp_if.tdir, byp_if.tdata}, {DIR_NORTH, m});
    check("t2_hs_ready", msg_if.tready, 1'b0);
    @(negedge clk);
    check("t2_after_valid", byp_if.tvalid, 1'b0);
    check("t2_after_ready", msg_if.tready, 1'b1);
    check("t2_after_idle", idle, 1'b1);

    // Routing sweep
    m = mk(1'b0, 4'd5, 4'd0, CMD_CONFIGURE, 21'h00123);
    byp_q.push_back({DIR_SOUTH, m});
    send(m, DIR_NORTH); @(negedge clk); count_busy(busy);
    check("t3_south_busy", busy, 1);
    m = mk(1'b0, 4'd2, 4'd7, CMD_LOAD_INSTR, 21'h0ABCD);
    byp_q.push_back({DIR_EAST, m});
    send(m, DIR_WEST); @(negedge clk); count_busy(busy);
    check("t3_east_busy", busy, 1);
    m = mk(1'b0, 4'd2, 4'd0, CMD_SIG_STATE, sig_pl(4'd3, 4'd3, 3'd3, 1'b1));
    byp_q.push_back({DIR_WEST, m});
    send(m, DIR_EAST); @(negedge clk); count_busy(busy);
    check("t3_west_busy", busy, 1);

    // Broadcast decay 5 from north
    m = mk(1'b1, 4'd0, 4'd5, CMD_SIG_STATE, sig_pl(4'd3, 4'd4, 3'd2, 1'b0));
    f = mk(1'b1, 4'd0, 4'd4, CMD_SIG_STATE, sig_pl(4'd3, 4'd4, 3'd2, 1'b0));
    sig_q.push_back({4'd3, 4'd4, 3'd2, 1'b0});
    byp_q.push_back({DIR_EAST, f});
    byp_q.push_back({DIR_SOUTH, f});
    byp_q.push_back({DIR_WEST, f});
    send(m, DIR_NORTH);
    @(negedge clk);
    check("t4_sig_n1", sig_valid, 1'b1);
    count_busy(busy);
    check("t4_busy", busy, 3);

    // Broadcast decay 1 from east, then decay 0
    instr_q.push_back(21'h1ABCDE);
    byp_q.push_back({DIR_WEST, mk(1'b1, 4'd0, 4'd0, CMD_LOAD_INSTR, 21'h1ABCDE)});
    send(mk(1'b1, 4'd0, 4'd1, CMD_LOAD_INSTR, 21'h1ABCDE), DIR_EAST);
    @(negedge clk);
    check("t5_instr_n1", instr_valid, 1'b1);
    count_busy(busy);
    check("t5_busy", busy, 1);
    sig_q.push_back({4'd7, 4'd8, 3'd1, 1'b1});
    send(mk(1'b1, 4'd0, 4'd0, CMD_SIG_STATE, sig_pl(4'd7, 4'd8, 3'd1, 1'b1)), DIR_SOUTH);
    @(negedge clk);
    check("t5_zero_sig", sig_valid, 1'b1);
    check("t5_zero_ready", msg_if.tready, 1'b1);
    check("t5_zero_byp", byp_if.tvalid, 1'b0);

    // Reserved command to self
    send(mk(1'b0, 4'd2, 4'd3, CMD_RESERVED, 21'h0F0F0), DIR_NORTH);
    @(negedge clk);
    check("t6_rsv_idle", idle, 1'b1);
    check("t6_rsv_byp", byp_if.tvalid, 1'b0);

    // CONFIGURE to self
    map_q.push_back({3'd4, 1'b1, 4'd1, 4'd2, 3'd3, 1'b0, 1'b0, 1'b1});
    send(mk(1'b0, 4'd2, 4'd3, CMD_CONFIGURE,
            cfg_pl({3'd4, 1'b1, 4'd1, 4'd2, 3'd3, 1'b0, 1'b0, 1'b1})), DIR_EAST);
    @(negedge clk);
    check("t6_map_n1", map_valid, 1'b1);
    @(negedge clk);
    check("t6_map_once", map_valid, 1'b0);

    // Reset during FWD
    byp_if.tready = 1'b0;
    send(mk(1'b0, 4'd5, 4'd0, CMD_SIG_STATE, sig_pl(4'd1, 4'd2, 3'd3, 1'b1)), DIR_NORTH);
    @(negedge clk);
    check("t7_fwd_valid", byp_if.tvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t7_rst_byp", byp_if.tvalid, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    byp_if.tready = 1'b1;
    @(negedge clk);
    check("t7_rel_ready", msg_if.tready, 1'b1);
    check("t7_rel_idle", idle, 1'b1);
    check("t7_rel_byp", byp_if.tvalid, 1'b0);

    repeat (2) @(negedge clk);
    check("end_sig_q", sig_q.size(), 0);
    check("end_map_q", map_q.size(), 0);
    check("end_instr_q", instr_q.size(), 0);
    check("end_byp_q", byp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
